// File: rtl/serv_rf_pkg.sv
// Shared types and sizing helpers for the SERV register-file RAM and its users.
package serv_rf_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Number of RAM words needed to hold 32 GPRs plus csr_regs CSRs of 32 bits each.
    function automatic int unsigned calc_depth(input int unsigned width, input int unsigned csr_regs);
        return 32 * (32 + csr_regs) / width;
    endfunction

endpackage

// File: rtl/serv_rf_ram_if.sv
// Write/read port bundle for the register-file RAM (one write port, one registered read port).
interface serv_rf_ram_if #(
    parameter int unsigned dw = 8,
    parameter int unsigned aw = 8
);
    logic [aw-1:0] waddr;
    logic [dw-1:0] wdata;
    logic          wen;
    logic [aw-1:0] raddr;
    logic          ren;
    logic [dw-1:0] rdata;

    modport master (output waddr, wdata, wen, raddr, ren, input rdata);
    modport slave  (input waddr, wdata, wen, raddr, ren, output rdata);
endinterface

// File: rtl/serv_rf_ram.sv
// Plain storage array: one write port, one registered read port, no reset (BRAM-inferable).
module serv_rf_ram #(
    parameter int unsigned dw    = 8,
    parameter int unsigned depth = 144,
    parameter int unsigned aw    = 8
) (
    input logic           i_clk,
    serv_rf_ram_if.slave  bus
);

    logic [dw-1:0] mem_q [depth];

    // Read and write in one block so a same-address access returns the old word.
    always_ff @(posedge i_clk) begin
        if (bus.wen) begin
            mem_q[bus.waddr] <= bus.wdata;
        end
        if (bus.ren) begin
            bus.rdata <= mem_q[bus.raddr];
        end
    end

endmodule

// File: rtl/serv_rf_ram_init.sv
// Register-file RAM that zeroes itself after reset before accepting accesses.
// Optional macro SERV_RF_PARITY_EN adds an even-parity bit per word and o_parity_err.
module serv_rf_ram_init
    import serv_rf_pkg::*;
#(
    parameter int unsigned width    = 8,
    parameter int unsigned csr_regs = 4,
    parameter int unsigned depth    = calc_depth(width, csr_regs),
    parameter int unsigned aw       = $clog2(depth)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [aw-1:0]    i_waddr,
    input  logic [width-1:0] i_wdata,
    input  logic             i_wen,
    input  logic [aw-1:0]    i_raddr,
    input  logic             i_ren,
    output logic [width-1:0] o_rdata,
    output logic             o_init_done
`ifdef SERV_RF_PARITY_EN
    ,
    output logic             o_parity_err
`endif
);

`ifdef SERV_RF_PARITY_EN
    localparam int unsigned DW = width + 1;
`else
    localparam int unsigned DW = width;
`endif
    localparam logic [aw-1:0] LAST = aw'(depth - 1);

    state_e          state_q, state_d;
    logic [aw-1:0]   cnt_q, cnt_d;
    logic            rd_ok_q, rd_ok_d;
    logic [DW-1:0]   wdata_ext;

    serv_rf_ram_if #(.dw(DW), .aw(aw)) ram_bus ();

`ifdef SERV_RF_PARITY_EN
    assign wdata_ext = {^i_wdata, i_wdata};
`else
    assign wdata_ext = i_wdata;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_ok_q <= rd_ok_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ram_bus.waddr = i_waddr;
        ram_bus.wdata = wdata_ext;
        ram_bus.wen   = 1'b0;
        ram_bus.raddr = i_raddr;
        ram_bus.ren   = 1'b0;
        case (state_q)
            CLEAR: begin
                ram_bus.waddr = cnt_q;
                ram_bus.wdata = '0;
                ram_bus.wen   = 1'b1;
                cnt_d         = cnt_q + aw'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                ram_bus.wen = i_wen;
                ram_bus.ren = i_ren;
            end
        endcase
        rd_ok_d = rd_ok_q | ram_bus.ren;
    end

    // The RAM read register has no reset; mask it until a read has happened since reset.
    assign o_rdata     = rd_ok_q ? ram_bus.rdata[width-1:0] : '0;
    assign o_init_done = (state_q == RUN);

`ifdef SERV_RF_PARITY_EN
    logic rd_pulse_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_pulse_q <= 1'b0;
        end else begin
            rd_pulse_q <= ram_bus.ren;
        end
    end

    assign o_parity_err = rd_pulse_q & (^ram_bus.rdata);
`endif

    serv_rf_ram #(.dw(DW), .depth(depth), .aw(aw)) u_ram (
        .i_clk (i_clk),
        .bus   (ram_bus.slave)
    );

endmodule

// File: tb/tb_serv_rf_ram_init.sv
// Self-checking bench for serv_rf_ram_init at default parameters (width 8, depth 144).
module tb_serv_rf_ram_init;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 144;
    localparam int unsigned AW    = 8;

    logic clk = 1'b0;
    logic rst;
    logic init_done;
`ifdef SERV_RF_PARITY_EN
    logic perr;
`endif

    int asserts = 0;
    int fails   = 0;

    logic [W-1:0] model [DEPTH];
    logic [W-1:0] exp_q [$];

    serv_rf_ram_if #(.dw(W), .aw(AW)) tb_bus ();

    always #5 clk = ~clk;

    serv_rf_ram_init #(.width(W), .csr_regs(4)) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_waddr     (tb_bus.waddr),
        .i_wdata     (tb_bus.wdata),
        .i_wen       (tb_bus.wen),
        .i_raddr     (tb_bus.raddr),
        .i_ren       (tb_bus.ren),
        .o_rdata     (tb_bus.rdata),
        .o_init_done (init_done)
`ifdef SERV_RF_PARITY_EN
        ,
        .o_parity_err(perr)
`endif
    );

    // All tasks start and end just after a falling edge.
    task automatic wait_init(input int start, input string tag);
        int cyc = start;
        while (init_done !== 1'b1 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        asserts++;
        if (cyc != 144) begin
            fails++;
            $display("FAIL %s init_done cycles: got %0d expected 144", tag, cyc);
        end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        tb_bus.wen   = 1'b1;
        tb_bus.waddr = a;
        tb_bus.wdata = d;
        model[a]     = d;
        @(negedge clk);
        tb_bus.wen   = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input string tag);
        logic [W-1:0] e;
        exp_q.push_back(model[a]);
        tb_bus.ren   = 1'b1;
        tb_bus.raddr = a;
        @(negedge clk);
        tb_bus.ren = 1'b0;
        e = exp_q.pop_front();
        asserts++;
        if (tb_bus.rdata !== e) begin
            fails++;
            $display("FAIL %s addr 0x%02h: got 0x%02h expected 0x%02h", tag, a, tb_bus.rdata, e);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        tb_bus.wen   = 1'b1;
        tb_bus.ren   = 1'b1;
        tb_bus.waddr = 8'd7;
        tb_bus.wdata = 8'hEE;
        tb_bus.raddr = 8'd7;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        asserts++;
        if (init_done !== 1'b0) begin
            fails++;
            $display("FAIL reset init_done: got %b expected 0", init_done);
        end
        asserts++;
        if (tb_bus.rdata !== 8'h00) begin
            fails++;
            $display("FAIL reset rdata: got 0x%02h expected 0x00", tb_bus.rdata);
        end
        // wen/ren stay high during the first 10 clear cycles and must be ignored
        repeat (10) @(negedge clk);
        asserts++;
        if (tb_bus.rdata !== 8'h00) begin
            fails++;
            $display("FAIL clear_rdata: got 0x%02h expected 0x00", tb_bus.rdata);
        end
        tb_bus.wen = 1'b0;
        tb_bus.ren = 1'b0;
        wait_init(10, "reset");
        for (int i = 0; i < DEPTH; i++) do_read(AW'(i), "clear_word");
    endtask

    task automatic test_write_read();
        do_write(8'h10, 8'hA5);
        do_read(8'h10, "wr_rd");
        tb_bus.raddr = 8'h20;
        repeat (3) @(negedge clk);
        asserts++;
        if (tb_bus.rdata !== 8'hA5) begin
            fails++;
            $display("FAIL rdata_hold: got 0x%02h expected 0xa5", tb_bus.rdata);
        end
        do_write(8'h00, 8'h5C);
        do_write(8'h8F, 8'hC3);
        do_read(8'h00, "addr_min");
        do_read(8'h8F, "addr_max");
    endtask

    task automatic test_same_addr();
        do_write(8'h20, 8'h11);
        exp_q.push_back(model[8'h20]);
        model[8'h20] = 8'h22;
        tb_bus.wen   = 1'b1;
        tb_bus.waddr = 8'h20;
        tb_bus.wdata = 8'h22;
        tb_bus.ren   = 1'b1;
        tb_bus.raddr = 8'h20;
        @(negedge clk);
        tb_bus.wen = 1'b0;
        tb_bus.ren = 1'b0;
        begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            asserts++;
            if (tb_bus.rdata !== e) begin
                fails++;
                $display("FAIL same_addr_old: got 0x%02h expected 0x%02h", tb_bus.rdata, e);
            end
        end
        do_read(8'h20, "same_addr_new");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            tb_bus.wen   = 1'b1;
            tb_bus.waddr = AW'(40 + i);
            tb_bus.wdata = W'($urandom_range(0, 255));
            model[40 + i] = tb_bus.wdata;
            @(negedge clk);
        end
        tb_bus.wen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (exp_q.size() != 0) begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                asserts++;
                if (tb_bus.rdata !== e) begin
                    fails++;
                    $display("FAIL b2b_read %0d: got 0x%02h expected 0x%02h", i, tb_bus.rdata, e);
                end
            end
            if (i < 8) begin
                tb_bus.ren   = 1'b1;
                tb_bus.raddr = AW'(40 + i);
                exp_q.push_back(model[40 + i]);
                @(negedge clk);
            end
        end
        tb_bus.ren = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tb_bus.wen   = 1'b1;
        tb_bus.waddr = 8'd9;
        tb_bus.wdata = 8'h5A;
        repeat (50) @(negedge clk);
        tb_bus.wen = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        asserts++;
        if (init_done !== 1'b0) begin
            fails++;
            $display("FAIL mid_clear init_done: got %b expected 0", init_done);
        end
        wait_init(0, "mid_clear");
        do_read(8'd9, "mid_clear_wen_ignored");
        do_read(8'h10, "mid_clear_word");
    endtask

    task automatic test_reset_mid_run();
        do_write(8'd3, 8'hFF);
        do_read(8'd3, "run_pre_reset");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        asserts++;
        if (tb_bus.rdata !== 8'h00 || init_done !== 1'b0) begin
            fails++;
            $display("FAIL mid_run reset: got rdata 0x%02h init %b expected 0x00 0", tb_bus.rdata, init_done);
        end
        wait_init(0, "mid_run");
        do_read(8'd3, "mid_run_word3");
    endtask

`ifdef SERV_RF_PARITY_EN
    task automatic test_parity();
        do_write(8'd5, 8'h3C);
        do_write(8'd6, 8'h3C);
        u_dut.u_ram.mem_q[5][W] = ~u_dut.u_ram.mem_q[5][W];
        tb_bus.ren   = 1'b1;
        tb_bus.raddr = 8'd5;
        @(negedge clk);
        tb_bus.ren = 1'b0;
        asserts++;
        if (perr !== 1'b1) begin
            fails++;
            $display("FAIL parity_err word5: got %b expected 1", perr);
        end
        @(negedge clk);
        asserts++;
        if (perr !== 1'b0) begin
            fails++;
            $display("FAIL parity_err pulse: got %b expected 0", perr);
        end
        tb_bus.ren   = 1'b1;
        tb_bus.raddr = 8'd6;
        @(negedge clk);
        tb_bus.ren = 1'b0;
        asserts++;
        if (perr !== 1'b0) begin
            fails++;
            $display("FAIL parity_err word6: got %b expected 0", perr);
        end
    endtask
`endif

    initial begin
        rst          = 1'b1;
        tb_bus.wen   = 1'b0;
        tb_bus.ren   = 1'b0;
        tb_bus.waddr = '0;
        tb_bus.wdata = '0;
        tb_bus.raddr = '0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_same_addr();
        test_back_to_back();
`ifdef SERV_RF_PARITY_EN
        test_parity();
`endif
        test_reset_mid_clear();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
